// File: rtl/ycr1_wbb_burst_mst.sv
// Wishbone-B burst master: moves one line between a local buffer and the bus per request.
// Optional beat watchdog enabled by defining YCR1_WBB_TIMEOUT_EN.
module ycr1_wbb_burst_mst #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int BL = 10,
    parameter int TW = 8
) (
    input  logic              wbm_clk_i,
    input  logic              wbm_rst_n,
    input  logic              req_i,
    input  logic              req_we_i,
    input  logic [AW-1:0]     req_adr_i,
    input  logic [BL-1:0]     req_bl_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [2:0]        status_o,
    output logic [BL-1:0]     buf_idx_o,
    input  logic [DW-1:0]     buf_wdata_i,
    output logic              buf_we_o,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic [AW-1:0]     wbm_adr_o,
    output logic              wbm_we_o,
    output logic [DW-1:0]     wbm_dat_o,
    output logic [DW/8-1:0]   wbm_sel_o,
    output logic [BL-1:0]     wbm_bl_o,
    input  logic [DW-1:0]     wbm_dat_i,
    input  logic              wbm_ack_i,
    input  logic              wbm_lack_i,
    input  logic              wbm_err_i
);

    localparam int BW = DW / 8;

    // Byte lanes must be whole and the watchdog needs a usable range.
    if ((DW % 8) != 0 || TW < 2) begin : g_bad_params
        $error("ycr1_wbb_burst_mst: DW must be a multiple of 8 and TW >= 2");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_GAP} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic            we_q, we_d;
    logic [BL-1:0]   len_q, len_d;
    logic [BL-1:0]   cnt_q, cnt_d;
    logic [2:0]      status_q, status_d;
    logic [BL:0]     cnt_inc;
    logic            in_burst;

`ifdef YCR1_WBB_TIMEOUT_EN
    logic [TW-1:0]   wdt_q, wdt_d;
`endif

    assign cnt_inc  = {1'b0, cnt_q} + {{BL{1'b0}}, 1'b1};
    assign in_burst = (state_q == ST_BURST);

    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        we_d     = we_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        status_d = status_q;
`ifdef YCR1_WBB_TIMEOUT_EN
        wdt_d    = wdt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    adr_d    = req_adr_i;
                    we_d     = req_we_i;
                    len_d    = req_bl_i;
                    cnt_d    = '0;
                    status_d = 3'b000;
`ifdef YCR1_WBB_TIMEOUT_EN
                    wdt_d    = '0;
`endif
                    if (req_bl_i != '0) begin
                        state_d = ST_BURST;
                    end else begin
                        // Zero-length request completes immediately without touching the bus.
                        state_d     = ST_GAP;
                        status_d[1] = 1'b1;
                    end
                end
            end
            ST_BURST: begin
                if (wbm_ack_i) begin
`ifdef YCR1_WBB_TIMEOUT_EN
                    wdt_d = '0;
`endif
                    if (cnt_q < len_q) begin
                        cnt_d = cnt_inc[BL-1:0];
                    end else begin
                        status_d[1] = 1'b1;
                    end
                    if (wbm_err_i) begin
                        status_d[0] = 1'b1;
                    end
                    if (wbm_lack_i) begin
                        state_d = ST_GAP;
                        if (cnt_inc != {1'b0, len_q}) begin
                            status_d[1] = 1'b1;
                        end
                    end
                end
`ifdef YCR1_WBB_TIMEOUT_EN
                else if (wdt_q == '1) begin
                    state_d     = ST_GAP;
                    status_d[2] = 1'b1;
                end else begin
                    wdt_d = wdt_q + {{(TW-1){1'b0}}, 1'b1};
                end
`endif
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wbm_clk_i or negedge wbm_rst_n) begin
        if (!wbm_rst_n) begin
            state_q  <= ST_IDLE;
            adr_q    <= '0;
            we_q     <= 1'b0;
            len_q    <= '0;
            cnt_q    <= '0;
            status_q <= 3'b000;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            we_q     <= we_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
        end
    end

`ifdef YCR1_WBB_TIMEOUT_EN
    always_ff @(posedge wbm_clk_i or negedge wbm_rst_n) begin
        if (!wbm_rst_n) begin
            wdt_q <= '0;
        end else begin
            wdt_q <= wdt_d;
        end
    end
`endif

    assign busy_o    = (state_q != ST_IDLE);
    assign done_o    = (state_q == ST_GAP);
    assign status_o  = status_q;
    assign buf_idx_o = cnt_q;
    // Beats past the requested length are acknowledged but never land in the buffer.
    assign buf_we_o  = in_burst & wbm_ack_i & ~we_q & (cnt_q < len_q);
    assign wbm_cyc_o = in_burst;
    assign wbm_stb_o = in_burst;
    assign wbm_adr_o = adr_q;
    assign wbm_we_o  = we_q;
    assign wbm_dat_o = (in_burst & we_q) ? buf_wdata_i : '0;
    assign wbm_sel_o = in_burst ? {BW{1'b1}} : {BW{1'b0}};
    assign wbm_bl_o  = len_q;

endmodule

// File: tb/tb_ycr1_wbb_burst_mst.sv
// Randomised bench for ycr1_wbb_burst_mst against a beat-list reference model.
// Build with YCR1_WBB_TIMEOUT_EN to exercise the watchdog at TW=4.
module tb_ycr1_wbb_burst_mst;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BL = 10;
`ifdef YCR1_WBB_TIMEOUT_EN
    localparam int TW = 4;
`else
    localparam int TW = 8;
`endif
    localparam int BW = DW / 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_i = 1'b0;
    logic              req_we_i = 1'b0;
    logic [AW-1:0]     req_adr_i = '0;
    logic [BL-1:0]     req_bl_i = '0;
    logic              busy_o, done_o, buf_we_o;
    logic [2:0]        status_o;
    logic [BL-1:0]     buf_idx_o;
    logic [DW-1:0]     buf_wdata_i;
    logic              wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [AW-1:0]     wbm_adr_o;
    logic [DW-1:0]     wbm_dat_o;
    logic [BW-1:0]     wbm_sel_o;
    logic [BL-1:0]     wbm_bl_o;
    logic [DW-1:0]     wbm_dat_i = '0;
    logic              wbm_ack_i = 1'b0;
    logic              wbm_lack_i = 1'b0;
    logic              wbm_err_i = 1'b0;

    ycr1_wbb_burst_mst #(.AW(AW), .DW(DW), .BL(BL), .TW(TW)) dut (
        .wbm_clk_i  (clk),
        .wbm_rst_n  (rst_n),
        .req_i      (req_i),
        .req_we_i   (req_we_i),
        .req_adr_i  (req_adr_i),
        .req_bl_i   (req_bl_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .status_o   (status_o),
        .buf_idx_o  (buf_idx_o),
        .buf_wdata_i(buf_wdata_i),
        .buf_we_o   (buf_we_o),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_bl_o   (wbm_bl_o),
        .wbm_dat_i  (wbm_dat_i),
        .wbm_ack_i  (wbm_ack_i),
        .wbm_lack_i (wbm_lack_i),
        .wbm_err_i  (wbm_err_i)
    );

    always #5 clk = ~clk;

    // Local line buffer: write source is read combinationally, read beats are logged.
    logic [DW-1:0] wbuf [0:(1<<BL)-1];
    assign buf_wdata_i = wbuf[buf_idx_o];

    typedef struct packed {
        logic [BL-1:0] idx;
        logic [DW-1:0] dat;
    } wr_t;

    wr_t got_q[$];
    wr_t exp_q[$];

    always @(posedge clk) begin
        if (buf_we_o) got_q.push_back({buf_idx_o, wbm_dat_i});
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Bus-side checks for any cycle while the burst is in flight; acks = beats acked so far.
    task automatic burst_cycle_checks(input bit we, input logic [AW-1:0] adr, input int bl,
                                      input int acks);
        int widx;
        widx = min2(acks, bl);
        check("cyc_stb", {wbm_cyc_o, wbm_stb_o}, 2'b11);
        check("sel", wbm_sel_o, {BW{1'b1}});
        check("adr", wbm_adr_o, adr);
        check("we", wbm_we_o, we);
        check("bl", wbm_bl_o, bl);
        check("busy", busy_o, 1);
        check("idx", buf_idx_o, widx);
        check("dat_o", wbm_dat_o, we ? wbuf[widx] : '0);
    endtask

    // One burst: nbeats acks, lack on the last; err_beat<0 means none; gap<0 means random.
    task automatic do_burst(input bit we, input logic [AW-1:0] adr, input int bl,
                            input int nbeats, input int err_beat, input int gap, input bit noisy);
        int acks;
        int ng;
        bit exp_bus_err;
        bit exp_len_err;
        logic [DW-1:0] d;
        for (int i = 0; i <= bl; i++) wbuf[i] = $urandom;
        exp_q.delete();
        got_q.delete();
        req_i = 1'b1; req_we_i = we; req_adr_i = adr; req_bl_i = BL'(bl);
        @(posedge clk); #1;
        req_i = 1'b0;
        acks = 0;
        exp_bus_err = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            ng = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            for (int g = 0; g < ng; g++) begin
                wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
                wbm_lack_i = noisy ? 1'($urandom) : 1'b0;
                req_i = noisy ? 1'($urandom) : 1'b0;
                #4;
                burst_cycle_checks(we, adr, bl, acks);
                check("bwe_idle", buf_we_o, 0);
                @(posedge clk); #1;
            end
            d = $urandom;
            wbm_ack_i = 1'b1; wbm_dat_i = d;
            wbm_err_i = (b == err_beat);
            wbm_lack_i = (b == nbeats - 1);
            req_i = noisy ? 1'($urandom) : 1'b0;
            #4;
            burst_cycle_checks(we, adr, bl, acks);
            check("bwe_ack", buf_we_o, (!we && acks < bl));
            if (!we && acks < bl) exp_q.push_back({BL'(acks), d});
            if (b == err_beat) exp_bus_err = 1'b1;
            acks++;
            @(posedge clk); #1;
        end
        wbm_ack_i = 1'b0; wbm_lack_i = 1'b0; wbm_err_i = 1'b0; req_i = 1'b0;
        exp_len_err = (nbeats != bl);
        #4;
        check("done", done_o, 1);
        check("status", status_o, {1'b0, exp_len_err, exp_bus_err});
        check("gap_cyc", {wbm_cyc_o, wbm_stb_o}, 2'b00);
        check("gap_busy", busy_o, 1);
        check("gap_bwe", buf_we_o, 0);
        @(posedge clk); #5;
        check("idle_done", done_o, 0);
        check("idle_busy", busy_o, 0);
        check("idle_stb", wbm_stb_o, 0);
        check("nwrites", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check("wr_entry", got_q[i], exp_q[i]);
        end
        $display("burst we=%0d adr=%08h bl=%0d beats=%0d err=%0d writes=%0d status=%03b",
                 we, adr, bl, nbeats, err_beat, got_q.size(), {1'b0, exp_len_err, exp_bus_err});
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_status"}, status_o, 0);
        check({tag, "_idx"}, buf_idx_o, 0);
        check({tag, "_bwe"}, buf_we_o, 0);
        check({tag, "_cyc_stb"}, {wbm_cyc_o, wbm_stb_o}, 0);
        check({tag, "_adr"}, wbm_adr_o, 0);
        check({tag, "_we"}, wbm_we_o, 0);
        check({tag, "_dat"}, wbm_dat_o, 0);
        check({tag, "_sel"}, wbm_sel_o, 0);
        check({tag, "_bl"}, wbm_bl_o, 0);
    endtask

    initial begin
        int cyc;
        bit dropped;
        for (int i = 0; i < (1 << BL); i++) wbuf[i] = '0;
        #3;
        check_all_zero("rst");
        #9 rst_n = 1'b1;
        @(posedge clk); #1;
        #4;
        check_all_zero("post_rst");
        @(posedge clk); #1;

        // Directed scenarios.
        do_burst(1'b0, 32'h1000, 4, 4, -1, 0, 1'b0);
        do_burst(1'b1, 32'h2000, 8, 8, -1, 1, 1'b0);
        do_burst(1'b0, 32'h3000, 4, 4, 1, 0, 1'b0);
        do_burst(1'b0, 32'h4000, 4, 2, -1, 0, 1'b0);
        do_burst(1'b0, 32'h5000, 2, 3, -1, 0, 1'b0);

        // Zero-length request: no bus activity, done on the following cycle.
        req_i = 1'b1; req_we_i = 1'b0; req_adr_i = 32'h6000; req_bl_i = '0;
        #4;
        check("bl0_stb_req", wbm_stb_o, 0);
        @(posedge clk); #1;
        req_i = 1'b0;
        #4;
        check("bl0_done", done_o, 1);
        check("bl0_status", status_o, 3'b010);
        check("bl0_stb", {wbm_cyc_o, wbm_stb_o}, 2'b00);
        @(posedge clk); #5;
        check("bl0_idle", busy_o, 0);
        $display("burst bl=0 status=010");
        @(posedge clk); #1;

        // Reset asserted mid-burst with an ack on the bus.
        req_i = 1'b1; req_we_i = 1'b1; req_adr_i = 32'h7000; req_bl_i = BL'(8);
        @(posedge clk); #1;
        req_i = 1'b0;
        wbm_ack_i = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        check("mid_busy_pre", busy_o, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        wbm_ack_i = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("mid-burst reset");

        // Randomised bursts with stray lack and ignored requests.
        for (int n = 0; n < 25; n++) begin
            int bl;
            int nb;
            int eb;
            bl = $urandom_range(1, 12);
            nb = bl + int'($urandom_range(0, 2)) - 1;
            if (nb < 1) nb = 1;
            eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
            do_burst(1'($urandom), $urandom, bl, nb, eb, -1, 1'b1);
        end

        // Bus that never acknowledges.
        req_i = 1'b1; req_we_i = 1'b0; req_adr_i = 32'h8000; req_bl_i = BL'(4);
        @(posedge clk); #1;
        req_i = 1'b0;
`ifdef YCR1_WBB_TIMEOUT_EN
        dropped = 1'b0;
        cyc = 0;
        while (!dropped && cyc < 40) begin
            #4;
            if (!wbm_stb_o) dropped = 1'b1;
            else begin
                cyc++;
                @(posedge clk); #1;
            end
        end
        check("wdt_dropped", dropped, 1);
        check("wdt_window", (cyc >= 15 && cyc <= 17), 1);
        check("wdt_done", done_o, 1);
        check("wdt_status", status_o, 3'b100);
        @(posedge clk); #5;
        check("wdt_idle", busy_o, 0);
        $display("watchdog stb low after %0d cycles status=%03b", cyc, status_o);
        @(posedge clk); #1;
`else
        dropped = 1'b0;
        for (cyc = 0; cyc < 100; cyc++) begin
            #4;
            if (!wbm_stb_o) dropped = 1'b1;
            @(posedge clk); #1;
        end
        #4;
        check("hang_never_dropped", dropped, 0);
        check("hang_stb", wbm_stb_o, 1);
        check("hang_busy", busy_o, 1);
        check("hang_status", status_o, 3'b000);
        $display("no watchdog: still in burst after %0d cycles", cyc);
        rst_n = 1'b0;
        #1;
        check_all_zero("hang_rst");
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
